// File: rtl/wb_write_buffer_if.sv
// rtl/wb_write_buffer_if.sv - Wishbone bus bundle with master and slave views
interface if_wb #(
    parameter int AWIDTH = 26,
    parameter int DWIDTH = 32
);
    logic [AWIDTH-1:0]   adr;
    logic [DWIDTH-1:0]   dat_m;
    logic [DWIDTH-1:0]   dat_s;
    logic [DWIDTH/8-1:0] sel;
    logic                we;
    logic                cyc;
    logic                stb;
    logic                ack;

    modport master (output adr, dat_m, sel, we, cyc, stb, input dat_s, ack);
    modport slave  (input adr, dat_m, sel, we, cyc, stb, output dat_s, ack);
endinterface

// File: rtl/wb_write_buffer.sv
// rtl/wb_write_buffer.sv - posted-write FIFO between CPU Wishbone and memory Wishbone (optional WBUF_MERGE_EN)
module wb_write_buffer #(
    parameter int AWIDTH = 26,
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    if_wb.slave        inbus,
    if_wb.master       outbus,
    output logic [1:0] wbuf_status
);
    localparam int SW = DWIDTH / 8;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    // queued write storage
    logic [AWIDTH-1:0] adr_mem_q [DEPTH];
    logic [DWIDTH-1:0] dat_mem_q [DEPTH];
    logic [SW-1:0]     sel_mem_q [DEPTH];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [1:0]        status_q, status_d;
    logic              in_ack_q, in_ack_d;

    state_t            state_q;
    logic              out_cyc_q;
    logic              out_we_q;
    logic [AWIDTH-1:0] out_adr_q;
    logic [DWIDTH-1:0] out_dat_q;
    logic [SW-1:0]     out_sel_q;
    logic [DWIDTH-1:0] in_dat_q;

    logic fifo_full, fifo_empty;
    logic wr_req, rd_req, wr_accept;
    logic push, pop, merge_hit;

`ifdef WBUF_MERGE_EN
    logic [PW-1:0]     last_ptr;
    logic [DWIDTH-1:0] merge_dat;
    logic [SW-1:0]     merge_sel;

    // Newest entry merge: only when it is not the head, since the head may already be on outbus
    always_comb begin
        last_ptr  = wr_ptr_q - 1'b1;
        merge_hit = wr_req && (count_q >= CW'(2)) && (inbus.adr == adr_mem_q[last_ptr]);
        merge_dat = dat_mem_q[last_ptr];
        for (int b = 0; b < SW; b++) begin
            if (inbus.sel[b]) begin
                merge_dat[8*b +: 8] = inbus.dat_m[8*b +: 8];
            end
        end
        merge_sel = sel_mem_q[last_ptr] | inbus.sel;
    end
`else
    assign merge_hit = 1'b0;
`endif

    // Accept/retire decisions and next occupancy; a retiring entry frees room for a same-cycle push
    always_comb begin
        fifo_full  = (count_q == CW'(DEPTH));
        fifo_empty = (count_q == '0);
        wr_req     = inbus.cyc && inbus.stb && inbus.we && !in_ack_q && (state_q != READ);
        rd_req     = inbus.cyc && inbus.stb && !inbus.we && !in_ack_q;
        pop        = (state_q == WRITE) && outbus.ack;
        wr_accept  = wr_req && (merge_hit || !fifo_full || pop);
        push       = wr_accept && !merge_hit;

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        status_d = {count_d == CW'(DEPTH), count_d == '0};
        in_ack_d = wr_accept || ((state_q == READ) && outbus.ack);
    end

    // Pointer, occupancy, status and CPU-side ack registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            status_q <= 2'b01;
            in_ack_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            status_q <= status_d;
            in_ack_q <= in_ack_d;
        end
    end

    // Entry storage: new writes go to the tail, merges update the newest entry in place
    always_ff @(posedge clk_i) begin
        if (push) begin
            adr_mem_q[wr_ptr_q] <= inbus.adr;
            dat_mem_q[wr_ptr_q] <= inbus.dat_m;
            sel_mem_q[wr_ptr_q] <= inbus.sel;
        end
`ifdef WBUF_MERGE_EN
        else if (merge_hit) begin
            dat_mem_q[last_ptr] <= merge_dat;
            sel_mem_q[last_ptr] <= merge_sel;
        end
`endif
    end

    // Memory-side sequencer: drains queued writes first, then serves a CPU read
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            out_cyc_q <= 1'b0;
            out_we_q  <= 1'b0;
            out_adr_q <= '0;
            out_dat_q <= '0;
            out_sel_q <= '0;
            in_dat_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_q   <= WRITE;
                        out_cyc_q <= 1'b1;
                        out_we_q  <= 1'b1;
                        out_adr_q <= adr_mem_q[rd_ptr_q];
                        out_dat_q <= dat_mem_q[rd_ptr_q];
                        out_sel_q <= sel_mem_q[rd_ptr_q];
                    end else if (rd_req) begin
                        state_q   <= READ;
                        out_cyc_q <= 1'b1;
                        out_we_q  <= 1'b0;
                        out_adr_q <= inbus.adr;
                        out_dat_q <= '0;
                        out_sel_q <= inbus.sel;
                    end
                end
                WRITE: begin
                    if (outbus.ack) begin
                        state_q   <= IDLE;
                        out_cyc_q <= 1'b0;
                        out_we_q  <= 1'b0;
                    end
                end
                READ: begin
                    if (outbus.ack) begin
                        state_q   <= IDLE;
                        out_cyc_q <= 1'b0;
                        in_dat_q  <= outbus.dat_s;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    out_cyc_q <= 1'b0;
                    out_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign outbus.cyc   = out_cyc_q;
    assign outbus.stb   = out_cyc_q;
    assign outbus.we    = out_we_q;
    assign outbus.adr   = out_adr_q;
    assign outbus.dat_m = out_dat_q;
    assign outbus.sel   = out_sel_q;
    assign inbus.ack    = in_ack_q;
    assign inbus.dat_s  = in_dat_q;
    assign wbuf_status  = status_q;
endmodule
